// File: rtl/vga_timing_config_pkg.sv
// Shared types and constants for the VGA timing-configuration block:
// preset 60 Hz timings, register offsets, FSM states and the timing-set record.
package vga_cfg_pkg;

    localparam int REZ_W    = 11;
    localparam int PULSE_W  = 8;
    localparam int MARGIN_W = 9;

    typedef struct packed {
        logic [REZ_W-1:0]    hcmax;
        logic [REZ_W-1:0]    vcmax;
        logic [PULSE_W-1:0]  hsync;
        logic [PULSE_W-1:0]  vsync;
        logic [MARGIN_W-1:0] hleft;
        logic [MARGIN_W-1:0] hright;
        logic [MARGIN_W-1:0] vleft;
        logic [MARGIN_W-1:0] vright;
    } timing_set_t;

    localparam logic [2:0] MODE_640X480   = 3'd0;
    localparam logic [2:0] MODE_800X600   = 3'd1;
    localparam logic [2:0] MODE_1024X768  = 3'd2;
    localparam logic [2:0] MODE_1280X1024 = 3'd3;
    localparam logic [2:0] MODE_CUSTOM    = 3'd4;

    localparam int OFS_MODE   = 0;
    localparam int OFS_HCMAX  = 1;
    localparam int OFS_VCMAX  = 2;
    localparam int OFS_HSYNC  = 3;
    localparam int OFS_VSYNC  = 4;
    localparam int OFS_HLEFT  = 5;
    localparam int OFS_HRIGHT = 6;
    localparam int OFS_VLEFT  = 7;
    localparam int OFS_VRIGHT = 8;
    localparam int OFS_COMMIT = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } cfg_state_t;

    localparam timing_set_t PRESET_640X480 = '{hcmax: 11'd799, vcmax: 11'd524,
        hsync: 8'd96, vsync: 8'd2, hleft: 9'd48, hright: 9'd16, vleft: 9'd33, vright: 9'd10};
    localparam timing_set_t PRESET_800X600 = '{hcmax: 11'd1055, vcmax: 11'd627,
        hsync: 8'd128, vsync: 8'd4, hleft: 9'd88, hright: 9'd40, vleft: 9'd23, vright: 9'd1};
    localparam timing_set_t PRESET_1024X768 = '{hcmax: 11'd1343, vcmax: 11'd805,
        hsync: 8'd136, vsync: 8'd6, hleft: 9'd160, hright: 9'd24, vleft: 9'd29, vright: 9'd3};
    localparam timing_set_t PRESET_1280X1024 = '{hcmax: 11'd1687, vcmax: 11'd1065,
        hsync: 8'd112, vsync: 8'd3, hleft: 9'd248, hright: 9'd48, vleft: 9'd38, vright: 9'd1};

    function automatic timing_set_t preset_set(input logic [2:0] mode);
        case (mode)
            MODE_800X600:   preset_set = PRESET_800X600;
            MODE_1024X768:  preset_set = PRESET_1024X768;
            MODE_1280X1024: preset_set = PRESET_1280X1024;
            default:        preset_set = PRESET_640X480;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_config_if.sv
// Configuration write bus of the VGA timing-configuration block, with the
// pending/error status flowing back to the bus master.
interface vga_timing_config_if #(
    parameter int CONFIG_WIDTH = 4,
    parameter int DATA_WIDTH   = 16
);
    logic                    valid;
    logic [CONFIG_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]   data;
    logic                    ready;
    logic                    err;

    modport master (output valid, addr, data, input ready, err);
    modport slave  (input valid, addr, data, output ready, err);
endinterface

// File: rtl/vga_timing_config_check.sv
// Combinational validator for a custom timing set: the sync pulse plus both
// porches must fit strictly inside the total count, horizontally and vertically.
module vga_timing_check
    import vga_cfg_pkg::*;
#(
    parameter int REZ_MAX_WIDTH = REZ_W
) (
    input  timing_set_t i_set,
    output logic        o_pass
);
    localparam int SUM_W = REZ_MAX_WIDTH + 2;

    logic [SUM_W-1:0] w_h_sum;
    logic [SUM_W-1:0] w_v_sum;

    // Two guard bits keep the three-term sums from wrapping
    always_comb begin
        w_h_sum = SUM_W'(i_set.hsync) + SUM_W'(i_set.hleft) + SUM_W'(i_set.hright);
        w_v_sum = SUM_W'(i_set.vsync) + SUM_W'(i_set.vleft) + SUM_W'(i_set.vright);
        o_pass  = (w_h_sum < SUM_W'(i_set.hcmax)) && (w_v_sum < SUM_W'(i_set.vcmax));
    end
endmodule

// File: rtl/vga_timing_config.sv
// Holds the active VGA timing set; bus writes stage a new set that is applied
// at a frame boundary (or right away) with a one-cycle load strobe.
module vga_timing_config
    import vga_cfg_pkg::*;
#(
    parameter int CONFIG_WIDTH  = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int BASE_ADDR     = 2,
    parameter int REZ_MAX_WIDTH = REZ_W,
    parameter int PULSE_WIDTH   = PULSE_W,
    parameter int MARGIN_WIDTH  = MARGIN_W,
    parameter int SYNC_TO_FRAME = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    vga_timing_config_if.slave      cfg_bus,
    input  logic                    i_frame_end,
    output logic [2:0]              o_mode_active,
    output logic                    o_load_config,
    output logic [PULSE_WIDTH-1:0]  o_h_sync_pulse,
    output logic [PULSE_WIDTH-1:0]  o_v_sync_pulse,
    output logic [REZ_MAX_WIDTH-1:0] o_h_count_max,
    output logic [REZ_MAX_WIDTH-1:0] o_v_count_max,
    output logic [MARGIN_WIDTH-1:0] o_h_left_margin,
    output logic [MARGIN_WIDTH-1:0] o_v_left_margin,
    output logic [MARGIN_WIDTH-1:0] o_h_right_margin,
    output logic [MARGIN_WIDTH-1:0] o_v_right_margin
);
    cfg_state_t              r_state, w_state_nxt;
    timing_set_t             r_shadow, r_stage, r_cur, w_stage_set;
    logic [2:0]              r_stage_mode, r_mode, w_sel_mode;
    logic                    r_restage, r_load, r_ready, r_err;
    logic                    w_sel, w_stage, w_err_set, w_custom_ok, w_apply, w_ready_nxt;
    logic [CONFIG_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    int                      w_ofs;

    assign w_addr = cfg_bus.addr;
    assign w_data = cfg_bus.data;
    assign w_ofs  = int'(w_addr) - BASE_ADDR;

    vga_timing_check #(.REZ_MAX_WIDTH(REZ_MAX_WIDTH)) u_check (
        .i_set  (r_shadow),
        .o_pass (w_custom_ok)
    );

    // Decode mode-select / commit writes into a staging request or an error
    always_comb begin
        w_sel      = 1'b0;
        w_sel_mode = MODE_640X480;
        w_stage    = 1'b0;
        w_err_set  = 1'b0;
        if (cfg_bus.valid && (w_ofs == OFS_MODE)) begin
            w_sel      = 1'b1;
            w_sel_mode = w_data[2:0];
        end else if (cfg_bus.valid && (w_ofs == OFS_COMMIT)) begin
            w_sel      = 1'b1;
            w_sel_mode = MODE_CUSTOM;
        end else begin
            w_sel      = 1'b0;
        end
        w_stage_set = preset_set(w_sel_mode);
        if (!w_sel) begin
            w_stage = 1'b0;
        end else if (w_sel_mode < MODE_CUSTOM) begin
            w_stage = 1'b1;
        end else if ((w_sel_mode == MODE_CUSTOM) && w_custom_ok) begin
            w_stage     = 1'b1;
            w_stage_set = r_shadow;
        end else begin
            w_err_set = 1'b1;
        end
    end

    // Custom shadow fields, truncated to their field widths on write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
        end else if (cfg_bus.valid) begin
            case (w_ofs)
                OFS_HCMAX:  r_shadow.hcmax  <= REZ_W'(w_data);
                OFS_VCMAX:  r_shadow.vcmax  <= REZ_W'(w_data);
                OFS_HSYNC:  r_shadow.hsync  <= PULSE_W'(w_data);
                OFS_VSYNC:  r_shadow.vsync  <= PULSE_W'(w_data);
                OFS_HLEFT:  r_shadow.hleft  <= MARGIN_W'(w_data);
                OFS_HRIGHT: r_shadow.hright <= MARGIN_W'(w_data);
                OFS_VLEFT:  r_shadow.vleft  <= MARGIN_W'(w_data);
                OFS_VRIGHT: r_shadow.vright <= MARGIN_W'(w_data);
                default:    r_shadow        <= r_shadow;
            endcase
        end
    end

    // Staged set: last accepted staging wins until it is applied
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage      <= PRESET_640X480;
            r_stage_mode <= MODE_640X480;
        end else if (w_stage) begin
            r_stage      <= w_stage_set;
            r_stage_mode <= w_sel_mode;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; r_restage covers a staging that arrived on the way into APPLY
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    w_state_nxt = w_stage ? ST_PENDING : ST_IDLE;
            ST_PENDING: w_state_nxt = ((SYNC_TO_FRAME == 0) || i_frame_end) ? ST_APPLY : ST_PENDING;
            ST_APPLY:   w_state_nxt = (w_stage || r_restage) ? ST_PENDING : ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs, looked ahead one state so the registered outputs line up with it
    always_comb begin
        w_apply     = (w_state_nxt == ST_APPLY);
        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // Registered timing outputs and status
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur     <= PRESET_640X480;
            r_mode    <= MODE_640X480;
            r_load    <= 1'b1;
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
            r_restage <= 1'b0;
        end else begin
            r_load    <= w_apply;
            r_ready   <= w_ready_nxt;
            r_restage <= w_apply && w_stage;
            if (w_apply) begin
                r_cur  <= r_stage;
                r_mode <= r_stage_mode;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_stage) begin
                r_err <= 1'b0;
            end
        end
    end

    assign cfg_bus.ready    = r_ready;
    assign cfg_bus.err      = r_err;
    assign o_mode_active    = r_mode;
    assign o_load_config    = r_load;
    assign o_h_count_max    = REZ_MAX_WIDTH'(r_cur.hcmax);
    assign o_v_count_max    = REZ_MAX_WIDTH'(r_cur.vcmax);
    assign o_h_sync_pulse   = PULSE_WIDTH'(r_cur.hsync);
    assign o_v_sync_pulse   = PULSE_WIDTH'(r_cur.vsync);
    assign o_h_left_margin  = MARGIN_WIDTH'(r_cur.hleft);
    assign o_h_right_margin = MARGIN_WIDTH'(r_cur.hright);
    assign o_v_left_margin  = MARGIN_WIDTH'(r_cur.vleft);
    assign o_v_right_margin = MARGIN_WIDTH'(r_cur.vright);
endmodule

// File: tb/tb_vga_timing_config.sv
// Bench for vga_timing_config: a frame-synchronous (index 1) and an immediate
// (index 0) instance share stimulus and are checked against a per-cycle model.
module tb_vga_timing_config;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tv = 1'b0;
    logic [3:0]  ta = 4'd0;
    logic [15:0] td = 16'd0;
    logic        tfe = 1'b0;

    logic [10:0] hcm [2];
    logic [10:0] vcm [2];
    logic [7:0]  hsp [2];
    logic [7:0]  vsp [2];
    logic [8:0]  hl  [2];
    logic [8:0]  hr  [2];
    logic [8:0]  vl  [2];
    logic [8:0]  vr  [2];
    logic [2:0]  mode [2];
    logic        load [2];
    logic [79:0] dut_vec [2];

    int n_total = 0;
    int n_bad   = 0;

    // model: fields ordered hcmax, vcmax, hsync, vsync, hleft, hright, vleft, vright
    int preset_tab [4][8] = '{'{799, 524, 96, 2, 48, 16, 33, 10},
                              '{1055, 627, 128, 4, 88, 40, 23, 1},
                              '{1343, 805, 136, 6, 160, 24, 29, 3},
                              '{1687, 1065, 112, 3, 248, 48, 38, 1}};
    int fw [8] = '{11, 11, 8, 8, 9, 9, 9, 9};
    int m_cur [2][8];
    int m_pset [2][8];
    int m_shadow [2][8];
    int m_cmode [2];
    int m_pmode [2];
    bit m_pend [2];
    bit m_load [2];
    bit m_ready [2];
    bit m_err [2];

    always #5 clk = ~clk;

    vga_timing_config_if #(.CONFIG_WIDTH(4), .DATA_WIDTH(16)) bus0 ();
    vga_timing_config_if #(.CONFIG_WIDTH(4), .DATA_WIDTH(16)) bus1 ();
    assign bus0.valid = tv;
    assign bus0.addr  = ta;
    assign bus0.data  = td;
    assign bus1.valid = tv;
    assign bus1.addr  = ta;
    assign bus1.data  = td;

    vga_timing_config #(.SYNC_TO_FRAME(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .cfg_bus(bus0), .i_frame_end(tfe),
        .o_mode_active(mode[0]), .o_load_config(load[0]),
        .o_h_sync_pulse(hsp[0]), .o_v_sync_pulse(vsp[0]),
        .o_h_count_max(hcm[0]), .o_v_count_max(vcm[0]),
        .o_h_left_margin(hl[0]), .o_v_left_margin(vl[0]),
        .o_h_right_margin(hr[0]), .o_v_right_margin(vr[0]));

    vga_timing_config #(.SYNC_TO_FRAME(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .cfg_bus(bus1), .i_frame_end(tfe),
        .o_mode_active(mode[1]), .o_load_config(load[1]),
        .o_h_sync_pulse(hsp[1]), .o_v_sync_pulse(vsp[1]),
        .o_h_count_max(hcm[1]), .o_v_count_max(vcm[1]),
        .o_h_left_margin(hl[1]), .o_v_left_margin(vl[1]),
        .o_h_right_margin(hr[1]), .o_v_right_margin(vr[1]));

    assign dut_vec[0] = {mode[0], load[0], bus0.ready, bus0.err, hcm[0], vcm[0],
                         hsp[0], vsp[0], hl[0], hr[0], vl[0], vr[0]};
    assign dut_vec[1] = {mode[1], load[1], bus1.ready, bus1.err, hcm[1], vcm[1],
                         hsp[1], vsp[1], hl[1], hr[1], vl[1], vr[1]};

    function automatic logic [79:0] exp_vec(input int k);
        exp_vec = {3'(m_cmode[k]), m_load[k], m_ready[k], m_err[k],
                   11'(m_cur[k][0]), 11'(m_cur[k][1]), 8'(m_cur[k][2]), 8'(m_cur[k][3]),
                   9'(m_cur[k][4]), 9'(m_cur[k][5]), 9'(m_cur[k][6]), 9'(m_cur[k][7])};
    endfunction

    function automatic bit custom_ok(input int s [8]);
        custom_ok = (s[2] + s[4] + s[5] < s[0]) && (s[3] + s[6] + s[7] < s[1]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cur[k]  = preset_tab[0];
            m_pset[k] = preset_tab[0];
            for (int i = 0; i < 8; i++) m_shadow[k][i] = 0;
            m_cmode[k] = 0;
            m_pmode[k] = 0;
            m_pend[k]  = 1'b0;
            m_load[k]  = 1'b1;
            m_ready[k] = 1'b1;
            m_err[k]   = 1'b0;
        end
    endtask

    // k = 0 applies whenever something is pending; k = 1 waits for frame_end
    task automatic model_step(input int k);
        int  ofs;
        int  nset [8];
        int  nmode;
        bit  stg;
        bit  app;
        ofs   = int'(ta) - 2;
        stg   = 1'b0;
        nmode = 0;
        nset  = preset_tab[0];
        if (tv && (ofs == 0 || ofs == 9)) begin
            nmode = (ofs == 9) ? 4 : int'(td[2:0]);
            if (nmode < 4) begin
                stg = 1'b1; nset = preset_tab[nmode]; m_err[k] = 1'b0;
            end else if (nmode == 4 && custom_ok(m_shadow[k])) begin
                stg = 1'b1; nset = m_shadow[k]; m_err[k] = 1'b0;
            end else begin
                m_err[k] = 1'b1;
            end
        end
        if (tv && ofs >= 1 && ofs <= 8)
            m_shadow[k][ofs-1] = int'(td) % (1 << fw[ofs-1]);
        app = m_pend[k] && !m_load[k] && ((k == 0) || tfe);
        if (app) begin
            m_cur[k]   = m_pset[k];
            m_cmode[k] = m_pmode[k];
        end
        m_load[k] = app;
        if (stg) begin
            m_pset[k]  = nset;
            m_pmode[k] = nmode;
            m_pend[k]  = 1'b1;
        end else if (app) begin
            m_pend[k] = 1'b0;
        end
        m_ready[k] = !m_pend[k] && !m_load[k];
    endtask

    task automatic step(input bit v, input logic [3:0] a, input logic [15:0] d, input bit fe);
        tv = v; ta = a; td = d; tfe = fe;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        @(negedge clk);
    endtask

    task automatic test_reset();
        tv = 1'b0; ta = 4'd0; td = 16'd0; tfe = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (dut_vec[k] !== exp_vec(k)) begin
                n_bad++; $display("FAIL reset_hold dut%0d got=%h want=%h", k, dut_vec[k], exp_vec(k));
            end
        end
        rst_n = 1'b1;
        #1;
        n_total++;
        if (load[1] !== 1'b1) begin n_bad++; $display("FAIL reset_load_first got=%b want=1", load[1]); end
        @(negedge clk);
        step(1'b0, 4'd0, 16'd0, 1'b0);
        n_total++;
        if (load[1] !== 1'b0) begin n_bad++; $display("FAIL reset_load_drop got=%b want=0", load[1]); end
        n_total++;
        if (hcm[1] !== 11'd799 || vsp[1] !== 8'd2) begin
            n_bad++; $display("FAIL reset_mode0 got=%0d/%0d want=799/2", hcm[1], vsp[1]);
        end
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (dut_vec[k] !== exp_vec(k)) begin
                n_bad++; $display("FAIL reset_state dut%0d got=%h want=%h", k, dut_vec[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_mode_switch();
        step(1'b1, 4'd2, 16'd2, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 4'd0, 16'd0, 1'b0);
            n_total++;
            if (bus1.ready !== 1'b0) begin n_bad++; $display("FAIL switch_ready[%0d] got=%b want=0", i, bus1.ready); end
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (dut_vec[k] !== exp_vec(k)) begin
                    n_bad++; $display("FAIL switch_wait[%0d] dut%0d got=%h want=%h", i, k, dut_vec[k], exp_vec(k));
                end
            end
        end
        step(1'b0, 4'd0, 16'd0, 1'b1);
        n_total++;
        if (hcm[1] !== 11'd1343 || vcm[1] !== 11'd805 || load[1] !== 1'b1 || mode[1] !== 3'd2) begin
            n_bad++; $display("FAIL switch_apply got=%0d/%0d/%b/%0d want=1343/805/1/2", hcm[1], vcm[1], load[1], mode[1]);
        end
        step(1'b0, 4'd0, 16'd0, 1'b0);
        n_total++;
        if (load[1] !== 1'b0 || bus1.ready !== 1'b1) begin
            n_bad++; $display("FAIL switch_after got=%b/%b want=0/1", load[1], bus1.ready);
        end
    endtask

    task automatic test_custom();
        logic [15:0] fields [8] = '{16'd999, 16'd600, 16'd100, 16'd5, 16'd50, 16'd20, 16'd20, 16'd10};
        for (int i = 0; i < 8; i++) step(1'b1, 4'(3 + i), fields[i], 1'b0);
        step(1'b1, 4'd11, 16'd0, 1'b0);
        step(1'b0, 4'd0, 16'd0, 1'b0);
        step(1'b0, 4'd0, 16'd0, 1'b1);
        n_total++;
        if (hcm[1] !== 11'd999 || hsp[1] !== 8'd100 || mode[1] !== 3'd4 || bus1.err !== 1'b0) begin
            n_bad++; $display("FAIL custom_apply got=%0d/%0d/%0d/%b want=999/100/4/0", hcm[1], hsp[1], mode[1], bus1.err);
        end
        // hsync 900 truncates to 132; 132+50+20 equals hcmax 202, so strict test fails
        step(1'b1, 4'd5, 16'd900, 1'b0);
        step(1'b1, 4'd3, 16'd202, 1'b0);
        step(1'b1, 4'd11, 16'd0, 1'b0);
        step(1'b0, 4'd0, 16'd0, 1'b1);
        n_total++;
        if (bus1.err !== 1'b1 || hcm[1] !== 11'd999 || load[1] !== 1'b0 || bus1.ready !== 1'b1) begin
            n_bad++; $display("FAIL custom_reject got=%b/%0d/%b/%b want=1/999/0/1", bus1.err, hcm[1], load[1], bus1.ready);
        end
        step(1'b1, 4'd3, 16'd203, 1'b0);
        step(1'b1, 4'd11, 16'd0, 1'b0);
        step(1'b0, 4'd0, 16'd0, 1'b1);
        n_total++;
        if (hcm[1] !== 11'd203 || hsp[1] !== 8'd132 || bus1.err !== 1'b0) begin
            n_bad++; $display("FAIL custom_boundary got=%0d/%0d/%b want=203/132/0", hcm[1], hsp[1], bus1.err);
        end
        step(1'b0, 4'd0, 16'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (dut_vec[k] !== exp_vec(k)) begin
                n_bad++; $display("FAIL custom_state dut%0d got=%h want=%h", k, dut_vec[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_bad_mode();
        step(1'b1, 4'd2, 16'd7, 1'b0);
        n_total++;
        if (bus1.err !== 1'b1 || bus1.ready !== 1'b1) begin
            n_bad++; $display("FAIL bad_mode got=%b/%b want=1/1", bus1.err, bus1.ready);
        end
        step(1'b1, 4'd2, 16'd1, 1'b0);
        n_total++;
        if (bus1.err !== 1'b0) begin n_bad++; $display("FAIL bad_mode_clear got=%b want=0", bus1.err); end
        step(1'b0, 4'd0, 16'd0, 1'b1);
        n_total++;
        if (hcm[1] !== 11'd1055 || mode[1] !== 3'd1) begin
            n_bad++; $display("FAIL bad_mode_apply got=%0d/%0d want=1055/1", hcm[1], mode[1]);
        end
        step(1'b0, 4'd0, 16'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int loads;
        step(1'b1, 4'd2, 16'd0, 1'b0);
        step(1'b0, 4'd0, 16'd0, 1'b1);
        step(1'b0, 4'd0, 16'd0, 1'b0);
        step(1'b1, 4'd2, 16'd1, 1'b0);
        step(1'b1, 4'd2, 16'd3, 1'b1);
        n_total++;
        if (hcm[1] !== 11'd1055 || mode[1] !== 3'd1 || load[1] !== 1'b1) begin
            n_bad++; $display("FAIL b2b_first got=%0d/%0d/%b want=1055/1/1", hcm[1], mode[1], load[1]);
        end
        loads = int'(load[1]);
        step(1'b0, 4'd0, 16'd0, 1'b0); loads += int'(load[1]);
        step(1'b0, 4'd0, 16'd0, 1'b0); loads += int'(load[1]);
        step(1'b0, 4'd0, 16'd0, 1'b1); loads += int'(load[1]);
        step(1'b0, 4'd0, 16'd0, 1'b0); loads += int'(load[1]);
        n_total++;
        if (loads != 2 || hcm[1] !== 11'd1687 || mode[1] !== 3'd3) begin
            n_bad++; $display("FAIL b2b_second got=%0d/%0d/%0d want=2/1687/3", loads, hcm[1], mode[1]);
        end
    endtask

    task automatic test_reset_pending();
        step(1'b1, 4'd2, 16'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (hcm[1] !== 11'd799 || bus1.ready !== 1'b1 || mode[1] !== 3'd0) begin
            n_bad++; $display("FAIL rst_pending got=%0d/%b/%0d want=799/1/0", hcm[1], bus1.ready, mode[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 4'd0, 16'd0, 1'b0);
        step(1'b0, 4'd0, 16'd0, 1'b1);
        n_total++;
        if (load[1] !== 1'b0 || hcm[1] !== 11'd799) begin
            n_bad++; $display("FAIL rst_pending_fe got=%b/%0d want=0/799", load[1], hcm[1]);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 4'd2 : 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), a, 16'($urandom), ($urandom_range(0, 7) == 0));
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (dut_vec[k] !== exp_vec(k)) begin
                    n_bad++; $display("FAIL random[%0d] dut%0d got=%h want=%h", i, k, dut_vec[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode_switch();
        test_custom();
        test_bad_mode();
        test_back_to_back();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
